// File: rtl/free_list.sv
// Circular free list of physical registers with a single read-pointer checkpoint for branch recovery.
// alloc_preg is the head, visible combinationally; frees land at the tail and can be allocated from the next cycle; frees into a full list are dropped and flagged.
module free_list #(
    parameter int NUM_PREGS = 128,
    parameter int NUM_AREGS = 32,
    localparam int PREG_W   = $clog2(NUM_PREGS),
    localparam int PTR_W    = PREG_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req,
    output logic              alloc_valid,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              free_valid,
    input  logic [PREG_W-1:0] free_preg,
    input  logic              ckpt_save,
    input  logic              mispredict,
    output logic [PTR_W-1:0]  free_count,
    output logic              overflow_err
);

    localparam int NUM_INIT_FREE = NUM_PREGS - NUM_AREGS;

    logic [PREG_W-1:0] r_mem [NUM_PREGS];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_ckpt_ptr;
    logic              r_overflow;

    logic w_alloc;
    logic w_full;
    logic w_free_req;
    logic w_free;
    logic w_drop;

    assign free_count   = r_wr_ptr - r_rd_ptr;
    assign alloc_valid  = (free_count != '0);
    assign alloc_preg   = r_mem[r_rd_ptr[PREG_W-1:0]];
    assign overflow_err = r_overflow;

    // A mispredict squashes the cycle's rename, so its allocation never happens.
    assign w_alloc    = alloc_req && alloc_valid && !mispredict;
    assign w_full     = (free_count == PTR_W'(NUM_PREGS));
    assign w_free_req = free_valid && (free_preg != '0);
    assign w_free     = w_free_req && !w_full;
    assign w_drop     = w_free_req && w_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                r_mem[i] <= (i < NUM_INIT_FREE) ? PREG_W'(NUM_AREGS + i) : '0;
            end
        end else if (w_free) begin
            r_mem[r_wr_ptr[PREG_W-1:0]] <= free_preg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= PTR_W'(NUM_INIT_FREE);
            r_overflow <= 1'b0;
        end else begin
            if (w_free) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // The snapshot counts the branch cycle's own allocation as already consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_ckpt_ptr <= '0;
        end else begin
            if (mispredict) begin
                r_rd_ptr <= r_ckpt_ptr;
            end else if (w_alloc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (ckpt_save && !mispredict) begin
                r_ckpt_ptr <= r_rd_ptr + PTR_W'(w_alloc);
            end
        end
    end

endmodule
